// File: rtl/writeback_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_queue_pkg
//  Description : Shared constants and entry type for the register-file
//                writeback queue and its pending-write lookup.
//  Revision    : 1.0  initial release
// ============================================================================
package writeback_queue_pkg;

    localparam int REG_WIDTH  = 64;
    localparam int REG_ADDR_W = 5;

    // Hard-wired zero register: writes are swallowed, lookups never hit
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd31;

    // One queued writeback: destination register and value
    typedef struct packed {
        logic [REG_ADDR_W-1:0] address;
        logic [REG_WIDTH-1:0]  data;
    } wbq_entry_t;

endpackage
`default_nettype wire

// File: rtl/writeback_queue_lookup.sv
`default_nettype none
// ============================================================================
//  Module      : wbq_lookup
//  Description : Combinational youngest-match search over the writeback
//                queue entries. Returns whether a queued write targets
//                i_select and, if so, the newest queued value for it.
//  Revision    : 1.0  initial release
// ============================================================================
module wbq_lookup
    import writeback_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = REG_WIDTH,
    parameter int ADDR_W = REG_ADDR_W
)(
    input  logic [DEPTH-1:0][ADDR_W-1:0] i_entry_addr,
    input  logic [DEPTH-1:0][WIDTH-1:0]  i_entry_data,
    input  logic [DEPTH-1:0]             i_entry_valid,
    input  logic [$clog2(DEPTH)-1:0]     i_wr_ptr,
    input  logic [ADDR_W-1:0]            i_select,
    output logic                         o_hit,
    output logic [WIDTH-1:0]             o_fwd
);

    localparam int                PTR_W      = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] c_zero_reg = ADDR_W'(ZERO_REG);

    logic [PTR_W-1:0] w_idx;

    // Scan slots starting at wr_ptr (oldest possible) toward wr_ptr-1
    // (youngest), so the last match seen is the newest pending value.
    always_comb begin
        o_hit = 1'b0;
        o_fwd = '0;
        w_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = i_wr_ptr + PTR_W'(i);
            if (i_entry_valid[w_idx] &&
                (i_entry_addr[w_idx] == i_select) &&
                (i_select != c_zero_reg)) begin
                o_hit = 1'b1;
                o_fwd = i_entry_data[w_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/writeback_queue.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_queue
//  Description : FIFO of register writebacks feeding the register file's
//                single write port, one write per cycle in program order.
//                Writes to the zero register are accepted and dropped.
//                DEPTH must be a power of two, at least 2.
//  Options     : WRITEBACK_QUEUE_BYPASS_EN - when defined, builds the two
//                pending-write lookup ports (hit_a/fwd_a, hit_b/fwd_b);
//                otherwise those outputs are tied to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = REG_WIDTH,
    parameter int ADDR_W = REG_ADDR_W
)(
    input  logic                     clock,
    input  logic                     reset,
    // producer side
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [ADDR_W-1:0]        in_address,
    // register file write port
    input  logic                     drain_hold,
    output logic [WIDTH-1:0]         out_data,
    output logic [ADDR_W-1:0]        out_address,
    output logic                     out_write,
    output logic [$clog2(DEPTH):0]   count,
    // pending-write lookup
    input  logic [ADDR_W-1:0]        select_a,
    input  logic [ADDR_W-1:0]        select_b,
    output logic                     hit_a,
    output logic                     hit_b,
    output logic [WIDTH-1:0]         fwd_a,
    output logic [WIDTH-1:0]         fwd_b
);

    localparam int                PTR_W      = $clog2(DEPTH);
    localparam int                CNT_W      = PTR_W + 1;
    localparam logic [ADDR_W-1:0] c_zero_reg = ADDR_W'(ZERO_REG);
    localparam logic [CNT_W-1:0]  c_full     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  c_empty    = '0;

    // queue state
    logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                count_q,  count_d;
    logic [DEPTH-1:0]                valid_q,  valid_d;
    logic [DEPTH-1:0][ADDR_W-1:0]    addr_q,   addr_d;
    logic [DEPTH-1:0][WIDTH-1:0]     data_q,   data_d;

    // handshake decode
    logic w_push;
    logic w_enq;
    logic w_pop;

    // Handshake and drain decode; all driven from registered state plus inputs
    always_comb begin
        in_ready    = (count_q != c_full);
        out_write   = (count_q != c_empty) && !drain_hold;
        out_data    = (count_q != c_empty) ? data_q[rd_ptr_q] : '0;
        out_address = (count_q != c_empty) ? addr_q[rd_ptr_q] : '0;
        count       = count_q;
        w_push      = in_valid && in_ready;
        // zero-register writes complete the handshake but never occupy a slot
        w_enq       = w_push && (in_address != c_zero_reg);
        w_pop       = out_write;
    end

    // Next-state for pointers, occupancy, valid mask and entry storage
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        addr_d   = addr_q;
        data_d   = data_q;

        // enqueue and pop never touch the same slot: a push is refused when full
        // and a pop cannot happen when empty
        if (w_enq) begin
            addr_d[wr_ptr_q]  = in_address;
            data_d[wr_ptr_q]  = in_data;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end

        if (w_pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end

        case ({w_enq, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State register; reset drops every queued write
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

`ifdef WRITEBACK_QUEUE_BYPASS_EN
    wbq_lookup #(
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_lookup_a (
        .i_entry_addr  (addr_q),
        .i_entry_data  (data_q),
        .i_entry_valid (valid_q),
        .i_wr_ptr      (wr_ptr_q),
        .i_select      (select_a),
        .o_hit         (hit_a),
        .o_fwd         (fwd_a)
    );

    wbq_lookup #(
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_lookup_b (
        .i_entry_addr  (addr_q),
        .i_entry_data  (data_q),
        .i_entry_valid (valid_q),
        .i_wr_ptr      (wr_ptr_q),
        .i_select      (select_b),
        .o_hit         (hit_b),
        .o_fwd         (fwd_b)
    );
`else
    // Without the bypass, consumers wait for the queue to empty; the lookup
    // ports stay on the interface but report nothing.
    logic w_unused_lookup;
    assign w_unused_lookup = ^{select_a, select_b, valid_q};
    assign hit_a = 1'b0;
    assign hit_b = 1'b0;
    assign fwd_a = '0;
    assign fwd_b = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_writeback_queue
//  Description : Self-checking bench for writeback_queue. A reference queue
//                tracks accepted writes; every cycle the DUT's drain port,
//                occupancy, ready and lookup outputs are compared with it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_writeback_queue;
    import writeback_queue_pkg::*;

    localparam int DEPTH  = 4;
    localparam int WIDTH  = 64;
    localparam int ADDR_W = 5;
`ifdef WRITEBACK_QUEUE_BYPASS_EN
    localparam bit c_bypass = 1'b1;
`else
    localparam bit c_bypass = 1'b0;
`endif

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic [ADDR_W-1:0]      in_address;
    logic                   drain_hold;
    logic [WIDTH-1:0]       out_data;
    logic [ADDR_W-1:0]      out_address;
    logic                   out_write;
    logic [$clog2(DEPTH):0] count;
    logic [ADDR_W-1:0]      select_a;
    logic [ADDR_W-1:0]      select_b;
    logic                   hit_a;
    logic                   hit_b;
    logic [WIDTH-1:0]       fwd_a;
    logic [WIDTH-1:0]       fwd_b;

    int n_checks = 0;
    int n_errors = 0;

    wbq_entry_t        sb_q[$];     // expected queue contents, oldest first
    logic [ADDR_W-1:0] wr_log[$];   // addresses the DUT wrote to the file
    int                exp_cnt;
    logic [WIDTH:0]    mdl_a;
    logic [WIDTH:0]    mdl_b;
    wbq_entry_t        new_e;

    writeback_queue #(
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_address  (in_address),
        .drain_hold  (drain_hold),
        .out_data    (out_data),
        .out_address (out_address),
        .out_write   (out_write),
        .count       (count),
        .select_a    (select_a),
        .select_b    (select_b),
        .hit_a       (hit_a),
        .hit_b       (hit_b),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // newest queued value for sel, as {hit, data}
    function automatic logic [WIDTH:0] model_lookup(input logic [ADDR_W-1:0] sel);
        logic [WIDTH:0] r = '0;
        if (c_bypass && sel != ZERO_REG) begin
            for (int i = 0; i < sb_q.size(); i++)
                if (sb_q[i].address == sel) r = {1'b1, sb_q[i].data};
        end
        return r;
    endfunction

    // Mid-cycle monitor: compare against the model, then apply the edge
    always @(negedge clock) begin
        if (reset) begin
            sb_q.delete();
        end else begin
            exp_cnt = sb_q.size();
            check_eq("count", count, 64'(exp_cnt));
            check_eq("in_ready", in_ready, 64'(exp_cnt != DEPTH));
            check_eq("out_write", out_write, 64'((exp_cnt != 0) && !drain_hold));
            if (exp_cnt != 0) begin
                check_eq("out_address", out_address, sb_q[0].address);
                check_eq("out_data", out_data, sb_q[0].data);
            end else begin
                check_eq("out_address_idle", out_address, 0);
                check_eq("out_data_idle", out_data, 0);
            end
            mdl_a = model_lookup(select_a);
            mdl_b = model_lookup(select_b);
            check_eq("hit_a", hit_a, mdl_a[WIDTH]);
            check_eq("fwd_a", fwd_a, mdl_a[WIDTH-1:0]);
            check_eq("hit_b", hit_b, mdl_b[WIDTH]);
            check_eq("fwd_b", fwd_b, mdl_b[WIDTH-1:0]);

            if (out_write) wr_log.push_back(out_address);
            if (exp_cnt != 0 && !drain_hold) void'(sb_q.pop_front());
            if (in_valid && exp_cnt != DEPTH && in_address != ZERO_REG) begin
                new_e.address = in_address;
                new_e.data    = in_data;
                sb_q.push_back(new_e);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // offer one write and wait (bounded) until it is accepted
    task automatic push(input logic [ADDR_W-1:0] addr, input logic [WIDTH-1:0] data);
        bit done = 1'b0;
        in_valid   = 1'b1;
        in_address = addr;
        in_data    = data;
        for (int k = 0; k < 50; k++) begin
            if (in_ready) begin
                done = 1'b1;
                break;
            end
            step();
        end
        check_eq("push_accept", 64'(done), 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        for (int k = 0; k < 60; k++) begin
            if (count == 0) break;
            step();
        end
        check_eq("drain_done", count, 0);
    endtask

    initial begin
        int next;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_address = '0;
        drain_hold = 1'b0;
        select_a   = '0;
        select_b   = '0;
        repeat (2) step();
        reset = 1'b0;

        // reset state
        check_eq("rst_out_write", out_write, 0);
        check_eq("rst_count", count, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_address", out_address, 0);
        check_eq("rst_hit_a", hit_a, 0);
        check_eq("rst_fwd_b", fwd_b, 0);

        // single write, minimum latency
        wr_log.delete();
        push(5'd3, 64'hAA);
        check_eq("t1_out_write", out_write, 1);
        check_eq("t1_out_address", out_address, 3);
        check_eq("t1_out_data", out_data, 64'hAA);
        step();
        check_eq("t1_count_after", count, 0);
        check_eq("t1_write_after", out_write, 0);
        check_eq("t1_log_size", 64'(wr_log.size()), 1);

        // fill while held, fifth push stalls, then program-order drain
        wr_log.delete();
        drain_hold = 1'b1;
        for (int i = 1; i <= 4; i++) push(ADDR_W'(i), 64'(i * 'h11));
        in_valid   = 1'b1;
        in_address = 5'd5;
        in_data    = 64'h55;
        check_eq("t2_full_ready", in_ready, 0);
        check_eq("t2_full_count", count, 4);
        step();
        check_eq("t2_still_full", in_ready, 0);
        drain_hold = 1'b0;
        check_eq("t2_ready_no_pop_dep", in_ready, 0);
        step();
        check_eq("t2_count_after_pop", count, 3);
        check_eq("t2_ready_after_pop", in_ready, 1);
        step();
        in_valid = 1'b0;
        wait_empty();
        check_eq("t2_log_size", 64'(wr_log.size()), 5);
        for (int i = 0; i < wr_log.size() && i < 5; i++)
            check_eq("t2_order", wr_log[i], 64'(i + 1));

        // zero register: handshake only
        wr_log.delete();
        in_valid   = 1'b1;
        in_address = 5'd31;
        in_data    = 64'hFF;
        check_eq("t3_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        check_eq("t3_count", count, 0);
        repeat (3) begin
            check_eq("t3_no_write", out_write, 0);
            step();
        end
        check_eq("t3_log_empty", 64'(wr_log.size()), 0);

        // lookup: youngest match wins, miss reports zero
        drain_hold = 1'b1;
        push(5'd7, 64'h10);
        push(5'd7, 64'h20);
        select_a = 5'd7;
        select_b = 5'd8;
        #1;
        check_eq("t4_hit_a", hit_a, 64'(c_bypass));
        check_eq("t4_fwd_a", fwd_a, c_bypass ? 64'h20 : 64'h0);
        check_eq("t4_hit_b", hit_b, 0);
        check_eq("t4_fwd_b", fwd_b, 0);
        select_a = 5'd31;
        #1;
        check_eq("t4_zero_reg_hit", hit_a, 0);
        select_a = 5'd0;
        drain_hold = 1'b0;
        wait_empty();

        // full queue, hold released with continuous push: overlap and wrap
        wr_log.delete();
        drain_hold = 1'b1;
        for (int i = 0; i < 4; i++) push(ADDR_W'(10 + i), 64'h100 + 64'(i));
        drain_hold = 1'b0;
        in_valid   = 1'b1;
        next       = 14;
        for (int c = 0; c < 6; c++) begin
            bit acc;
            in_address = ADDR_W'(next);
            in_data    = 64'h100 + 64'(next - 10);
            check_eq("t5_count", count, (c == 0) ? 4 : 3);
            acc = in_ready;
            step();
            if (acc) next++;
        end
        in_valid = 1'b0;
        wait_empty();
        check_eq("t5_log_size", 64'(wr_log.size()), 9);
        for (int i = 0; i < wr_log.size() && i < 9; i++)
            check_eq("t5_order", wr_log[i], 64'(10 + i));

        // reset with queued writes discards them
        wr_log.delete();
        drain_hold = 1'b1;
        push(5'd20, 64'hA0);
        push(5'd21, 64'hA1);
        push(5'd22, 64'hA2);
        select_a = 5'd21;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        check_eq("t6_out_write", out_write, 0);
        check_eq("t6_count", count, 0);
        check_eq("t6_hit_a", hit_a, 0);
        check_eq("t6_fwd_a", fwd_a, 0);
        drain_hold = 1'b0;
        repeat (4) step();
        check_eq("t6_no_writes", 64'(wr_log.size()), 0);
        check_eq("t6_count_idle", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
